t48_branch_seq: RTL

- Sequencer for the T48 conditional-branch evaluator; sits between the opcode fetch path and the evaluator.
- Decodes conditional-jump opcodes and drives the evaluator's condition code, compare value and compute strobe.
- Captures the second-byte target address, samples the registered take decision and issues a single PC-low load when the branch is taken.

---
 rtl/t48_branch_pkg.sv | 47 ++++
 rtl/t48_branch_seq_if.sv | 40 ++++
 rtl/t48_branch_decode.sv | 34 +++
 rtl/t48_branch_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/t48_branch_pkg.sv
// Shared constants and types for the T48 conditional-branch sequencer.
// Optional statistics counters are enabled by defining T48_BRANCH_STATS_EN.
package t48_branch_pkg;

    localparam int CNT_W = 8;

    localparam logic [3:0] COND_JB = 4'b0000;
    localparam logic [3:0] COND_Z  = 4'b0001;
    localparam logic [3:0] COND_C  = 4'b0010;
    localparam logic [3:0] COND_F0 = 4'b0011;
    localparam logic [3:0] COND_F1 = 4'b0100;
    localparam logic [3:0] COND_NI = 4'b0101;
    localparam logic [3:0] COND_T0 = 4'b0110;
    localparam logic [3:0] COND_T1 = 4'b0111;
    localparam logic [3:0] COND_TF = 4'b1000;

    // JBb is xxx10010 with the bit index in opcode[7:5]
    localparam logic [7:0] OPC_JB_MASK = 8'h1F;
    localparam logic [7:0] OPC_JB_PAT  = 8'h12;
    localparam logic [7:0] OPC_JZ      = 8'hC6;
    localparam logic [7:0] OPC_JNZ     = 8'h96;
    localparam logic [7:0] OPC_JC      = 8'hF6;
    localparam logic [7:0] OPC_JNC     = 8'hE6;
    localparam logic [7:0] OPC_JF0     = 8'hB6;
    localparam logic [7:0] OPC_JF1     = 8'h76;
    localparam logic [7:0] OPC_JNI     = 8'h86;
    localparam logic [7:0] OPC_JT0     = 8'h36;
    localparam logic [7:0] OPC_JNT0    = 8'h26;
    localparam logic [7:0] OPC_JT1     = 8'h56;
    localparam logic [7:0] OPC_JNT1    = 8'h46;
    localparam logic [7:0] OPC_JTF     = 8'h16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_ADDR   = 3'd3,
        ST_DECIDE = 3'd4
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] cond;
        logic [2:0] comp;
    } dec_t;

endpackage

// File: rtl/t48_branch_seq_if.sv
// Opcode/address/evaluator signal bundle of the T48 branch sequencer.
// Counter outputs exist only when T48_BRANCH_STATS_EN is defined.
interface t48_branch_seq_if #(parameter int ADDR_W = 8);

    logic              en_clk_i;
    logic              opc_valid_i;
    logic [7:0]        opc_i;
    logic              addr_valid_i;
    logic [ADDR_W-1:0] addr_i;
    logic              take_branch_i;
    logic [3:0]        branch_cond_o;
    logic [2:0]        comp_value_o;
    logic              compute_take_o;
    logic              pc_load_o;
    logic [ADDR_W-1:0] pc_low_o;
    logic              busy_o;
`ifdef T48_BRANCH_STATS_EN
    logic [7:0]        taken_cnt_o;
    logic [7:0]        eval_cnt_o;
`endif

    modport master (
        output en_clk_i, opc_valid_i, opc_i, addr_valid_i, addr_i, take_branch_i,
        input  branch_cond_o, comp_value_o, compute_take_o, pc_load_o, pc_low_o,
        input  busy_o
`ifdef T48_BRANCH_STATS_EN
        , input taken_cnt_o, eval_cnt_o
`endif
    );

    modport slave (
        input  en_clk_i, opc_valid_i, opc_i, addr_valid_i, addr_i, take_branch_i,
        output branch_cond_o, comp_value_o, compute_take_o, pc_load_o, pc_low_o,
        output busy_o
`ifdef T48_BRANCH_STATS_EN
        , output taken_cnt_o, eval_cnt_o
`endif
    );

endinterface

// File: rtl/t48_branch_decode.sv
// Combinational decode of T48 conditional-jump opcodes into the
// evaluator condition code and compare value.
module t48_branch_decode
    import t48_branch_pkg::*;
(
    input  logic [7:0] opc_i,
    output dec_t       dec_o
);

    always_comb begin
        // NOTE: assigning a default before any branch keeps this purely combinational (no latch).
        dec_o = '0;
        if ((opc_i & OPC_JB_MASK) == OPC_JB_PAT) begin
            dec_o = '{hit: 1'b1, cond: COND_JB, comp: opc_i[7:5]};
        end else begin
            case (opc_i)
                OPC_JZ:   dec_o = '{hit: 1'b1, cond: COND_Z,  comp: 3'd1};
                OPC_JNZ:  dec_o = '{hit: 1'b1, cond: COND_Z,  comp: 3'd0};
                OPC_JC:   dec_o = '{hit: 1'b1, cond: COND_C,  comp: 3'd1};
                OPC_JNC:  dec_o = '{hit: 1'b1, cond: COND_C,  comp: 3'd0};
                OPC_JF0:  dec_o = '{hit: 1'b1, cond: COND_F0, comp: 3'd0};
                OPC_JF1:  dec_o = '{hit: 1'b1, cond: COND_F1, comp: 3'd0};
                OPC_JNI:  dec_o = '{hit: 1'b1, cond: COND_NI, comp: 3'd0};
                OPC_JT0:  dec_o = '{hit: 1'b1, cond: COND_T0, comp: 3'd1};
                OPC_JNT0: dec_o = '{hit: 1'b1, cond: COND_T0, comp: 3'd0};
                OPC_JT1:  dec_o = '{hit: 1'b1, cond: COND_T1, comp: 3'd1};
                OPC_JNT1: dec_o = '{hit: 1'b1, cond: COND_T1, comp: 3'd0};
                OPC_JTF:  dec_o = '{hit: 1'b1, cond: COND_TF, comp: 3'd0};
                default:  dec_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/t48_branch_seq.sv
// T48 conditional-branch sequencer: opcode decode, evaluate strobe, target capture
// and PC-low load. Define T48_BRANCH_STATS_EN for taken/evaluate counters.
module t48_branch_seq
    import t48_branch_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk_i,
    input  logic            res_i,
    t48_branch_seq_if.slave bus
);

    state_e            state_q, state_d;
    dec_t              dec;
    logic              accept;
    logic              take_now;
    logic [3:0]        cond_q, cond_d;
    logic [2:0]        comp_q, comp_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              have_addr_q, have_addr_d;
    logic [ADDR_W-1:0] pc_low_q, pc_low_d;
    logic              pc_load_q, pc_load_d;

    t48_branch_decode u_decode (
        .opc_i (bus.opc_i),
        .dec_o (dec)
    );

    assign accept   = bus.en_clk_i && (state_q == ST_IDLE) && bus.opc_valid_i && dec.hit;
    assign take_now = bus.en_clk_i && (state_q == ST_DECIDE) && bus.take_branch_i;

    // State register
    always_ff @(posedge clk_i or posedge res_i) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (res_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.en_clk_i) begin
            case (state_q)
                ST_IDLE:   if (bus.opc_valid_i && dec.hit) state_d = ST_EVAL;
                ST_EVAL:   state_d = ST_WAIT;
                ST_WAIT:   state_d = (have_addr_q || bus.addr_valid_i) ? ST_DECIDE : ST_ADDR;
                ST_ADDR:   if (bus.addr_valid_i) state_d = ST_DECIDE;
                ST_DECIDE: state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output and datapath logic
    always_comb begin
        cond_d      = cond_q;
        comp_d      = comp_q;
        addr_d      = addr_q;
        have_addr_d = have_addr_q;
        pc_low_d    = pc_low_q;
        pc_load_d   = pc_load_q;
        if (bus.en_clk_i) begin
            pc_load_d = 1'b0;
            if (accept) begin
                cond_d      = dec.cond;
                comp_d      = dec.comp;
                have_addr_d = 1'b0;
            end
            // Only the first address of a sequence is kept
            if ((state_q == ST_EVAL || state_q == ST_WAIT || state_q == ST_ADDR) &&
                bus.addr_valid_i && !have_addr_q) begin
                addr_d      = bus.addr_i;
                have_addr_d = 1'b1;
            end
            if (take_now) begin
                pc_load_d = 1'b1;
                pc_low_d  = addr_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            cond_q      <= '0;
            comp_q      <= '0;
            addr_q      <= '0;
            have_addr_q <= 1'b0;
            pc_low_q    <= '0;
            pc_load_q   <= 1'b0;
        end else begin
            cond_q      <= cond_d;
            comp_q      <= comp_d;
            addr_q      <= addr_d;
            have_addr_q <= have_addr_d;
            pc_low_q    <= pc_low_d;
            pc_load_q   <= pc_load_d;
        end
    end

    assign bus.branch_cond_o  = cond_q;
    assign bus.comp_value_o   = comp_q;
    assign bus.compute_take_o = (state_q == ST_EVAL);
    assign bus.busy_o         = (state_q != ST_IDLE);
    assign bus.pc_load_o      = pc_load_q;
    assign bus.pc_low_o       = pc_low_q;

`ifdef T48_BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] eval_cnt_q, eval_cnt_d;

    // Counters step on the edge that raises their strobe, so they track it directly
    always_comb begin
        taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, take_now};
        eval_cnt_d  = eval_cnt_q  + {{(CNT_W-1){1'b0}}, accept};
    end

    always_ff @(posedge clk_i or posedge res_i) begin
        if (res_i) begin
            taken_cnt_q <= '0;
            eval_cnt_q  <= '0;
        end else begin
            taken_cnt_q <= taken_cnt_d;
            eval_cnt_q  <= eval_cnt_d;
        end
    end

    assign bus.taken_cnt_o = taken_cnt_q;
    assign bus.eval_cnt_o  = eval_cnt_q;
`else
    // No statistics state in the default build
`endif

endmodule
